// File: rtl/uart_tx_queue.sv
// Purpose     : byte FIFO plus launch FSM feeding the UART transmitter; CPU writes
//               push bytes, the FSM pops one at a time and fires a one-cycle start strobe.
// Latency     : a byte pushed on edge N into an empty queue with the transmitter idle
//               is launched on edge N+1 (strobe and data registered together).
// Backpressure: waits for tx_busy to rise and fall before the next launch; pushes into a
//               full queue are dropped unless a pop happens on the same edge.
//
// Ports:
//   clk, reset            - system clock; asynchronous active-high reset
//   wr_en, wr_data        - one-cycle push request and byte from the CPU bus
//   tx_busy               - transmitter busy, high from start acceptance through stop bit
//   tx_strobe_start       - one-cycle launch pulse to the transmitter
//   tx_parallel_data_out  - registered byte for the transmitter, stable until the next pop
//   status_full/empty     - occupancy == DEPTH / occupancy == 0
//   status_count          - current occupancy (CNT_W bits)
//   status_overflow       - sticky dropped-write flag, cleared by ovf_clear
//
// Build option: define UART_TX_QUEUE_OVERFLOW_EN to enable the sticky overflow flag.
// Without it status_overflow is tied low and ovf_clear is ignored; drops behave the same.

module uart_tx_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,                  // power of two, >= 2
  parameter int CNT_W      = $clog2(DEPTH) + 1   // derived; leave at default
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  tx_busy,
  output logic                  tx_strobe_start,
  output logic [DATA_WIDTH-1:0] tx_parallel_data_out,
  output logic                  status_full,
  output logic                  status_empty,
  output logic [CNT_W-1:0]      status_count,
  output logic                  status_overflow,
  input  logic                  ovf_clear
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  strobe_q, strobe_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Pop only looks at registered occupancy, so a byte pushed into an empty queue
  // is never bypassed straight to the transmitter; it launches one edge later.
  assign pop  = (state_q == S_IDLE) && !empty && !tx_busy;

  // A pop on the same edge frees the head slot, so a push at full still lands.
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    strobe_d = 1'b0;
    data_d   = data_q;
    mem_d    = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    // Reads the pre-edge storage, so a push-at-full writing the head slot
    // cannot corrupt the byte being launched.
    if (pop) begin
      data_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      strobe_d = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Launch FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_WAIT_BUSY;
      end
      // The transmitter raises busy a cycle or more after the strobe; waiting for
      // the rising edge first keeps a stale low busy from re-launching early.
      S_WAIT_BUSY: begin
        if (tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      strobe_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
    end
  end

  // Storage is not reset: contents are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------------
  // Sticky overflow flag
  // ---------------------------------------------------------------------------
`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // A drop in the same cycle as a clear keeps the flag set so no drop goes unseen.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clear) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign status_overflow = ovf_q;
`else
  logic unused_ovf_inputs;
  assign unused_ovf_inputs = ovf_clear ^ drop;
  assign status_overflow   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx_strobe_start      = strobe_q;
  assign tx_parallel_data_out = data_q;
  assign status_full          = full;
  assign status_empty         = empty;
  assign status_count         = count_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: a behavioural transmitter raises busy for a
// fixed frame after each start strobe and records every launched byte in order.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.

module tb_uart_tx_queue;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int FRAME = 10;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          tx_busy;
  logic          tx_strobe_start;
  logic [DW-1:0] tx_parallel_data_out;
  logic          status_full;
  logic          status_empty;
  logic [CW-1:0] status_count;
  logic          status_overflow;
  logic          ovf_clear;

  int errors;
  int checks;

`ifdef UART_TX_QUEUE_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  uart_tx_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .reset                (reset),
    .wr_en                (wr_en),
    .wr_data              (wr_data),
    .tx_busy              (tx_busy),
    .tx_strobe_start      (tx_strobe_start),
    .tx_parallel_data_out (tx_parallel_data_out),
    .status_full          (status_full),
    .status_empty         (status_empty),
    .status_count         (status_count),
    .status_overflow      (status_overflow),
    .ovf_clear            (ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural transmitter: busy for FRAME cycles after each strobe, or held by tx_hold.
  logic          tx_hold;
  logic          model_busy;
  int            frame_cnt;
  int            pulse_cnt;
  int            launch_viol;
  logic [DW-1:0] rx_q[$];

  assign tx_busy = tx_hold | model_busy;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      model_busy = 1'b0;
      frame_cnt  = 0;
    end else if (tx_strobe_start) begin
      if (tx_busy) launch_viol++;
      rx_q.push_back(tx_parallel_data_out);
      pulse_cnt++;
      model_busy = 1'b1;
      frame_cnt  = FRAME;
    end else if (frame_cnt > 0) begin
      frame_cnt--;
      if (frame_cnt == 0) model_busy = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rx_q.delete();
    pulse_cnt   = 0;
    launch_viol = 0;
  endtask

  // Waits (bounded) for n launches and the last frame to finish, then idles a while
  // so any spurious extra launch would show up in pulse_cnt.
  task automatic wait_pulses(input int n, input string name);
    int cyc;
    cyc = 0;
    while ((pulse_cnt < n || tx_busy) && cyc < 1000) begin
      tick();
      cyc++;
    end
    repeat (30) tick();
    checks++;
    if (pulse_cnt !== n) begin
      errors++;
      $display("FAIL %s pulses: got %0d, expected %0d", name, pulse_cnt, n);
    end
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++; if (tx_strobe_start !== 1'b0) begin errors++; $display("FAIL reset strobe: got %b, expected 0", tx_strobe_start); end
    checks++; if (tx_parallel_data_out !== 8'h00) begin errors++; $display("FAIL reset data: got %h, expected 00", tx_parallel_data_out); end
    checks++; if (status_empty !== 1'b1) begin errors++; $display("FAIL reset empty: got %b, expected 1", status_empty); end
    checks++; if (status_full !== 1'b0) begin errors++; $display("FAIL reset full: got %b, expected 0", status_full); end
    checks++; if (status_count !== 3'd0) begin errors++; $display("FAIL reset count: got %0d, expected 0", status_count); end
    checks++; if (status_overflow !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b, expected 0", status_overflow); end
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    clear_log();
    push_byte(8'h41);             // edge N
    checks++; if (tx_strobe_start !== 1'b0) begin errors++; $display("FAIL single no_bypass strobe: got %b, expected 0", tx_strobe_start); end
    checks++; if (status_count !== 3'd1) begin errors++; $display("FAIL single count: got %0d, expected 1", status_count); end
    tick();                       // edge N+1
    checks++; if (tx_strobe_start !== 1'b1) begin errors++; $display("FAIL single strobe N+1: got %b, expected 1", tx_strobe_start); end
    checks++; if (tx_parallel_data_out !== 8'h41) begin errors++; $display("FAIL single data: got %h, expected 41", tx_parallel_data_out); end
    checks++; if (status_empty !== 1'b1) begin errors++; $display("FAIL single empty after pop: got %b, expected 1", status_empty); end
    tick();                       // edge N+2
    checks++; if (tx_strobe_start !== 1'b0) begin errors++; $display("FAIL single strobe width: got %b, expected 0", tx_strobe_start); end
    checks++; if (tx_parallel_data_out !== 8'h41) begin errors++; $display("FAIL single data held: got %h, expected 41", tx_parallel_data_out); end
    wait_pulses(1, "single");
    checks++; if (rx_q.size() < 1 || rx_q[0] !== 8'h41) begin errors++; $display("FAIL single rx byte: got %h, expected 41", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
  endtask

  task automatic test_burst_order();
    logic [DW-1:0] exp_b [3];
    exp_b = '{8'h48, 8'h69, 8'h21};
    clear_log();
    tx_hold = 1'b1;               // keep bytes queued so the count can reach 3
    foreach (exp_b[i]) begin
      wr_en   = 1'b1;
      wr_data = exp_b[i];
      tick();
    end
    wr_en = 1'b0;
    checks++; if (status_count !== 3'd3) begin errors++; $display("FAIL burst count: got %0d, expected 3", status_count); end
    tx_hold = 1'b0;
    wait_pulses(3, "burst");
    foreach (exp_b[i]) begin
      checks++;
      if (rx_q.size() <= i || rx_q[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL burst rx[%0d]: got %h, expected %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++; if (launch_viol !== 0) begin errors++; $display("FAIL burst launch_while_busy: got %0d, expected 0", launch_viol); end
  endtask

  task automatic test_full_drop();
    clear_log();
    tx_hold = 1'b1;
    for (int i = 1; i <= 5; i++) push_byte(DW'(i));
    checks++; if (status_full !== 1'b1) begin errors++; $display("FAIL drop full: got %b, expected 1", status_full); end
    checks++; if (status_count !== 3'd4) begin errors++; $display("FAIL drop count: got %0d, expected 4", status_count); end
    checks++; if (status_overflow !== EXP_OVF) begin errors++; $display("FAIL drop ovf: got %b, expected %b", status_overflow, EXP_OVF); end
    checks++; if (pulse_cnt !== 0) begin errors++; $display("FAIL drop hold_no_pop: got %0d, expected 0", pulse_cnt); end
    tx_hold = 1'b0;
    wait_pulses(4, "drop");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q.size() <= i || rx_q[i] !== DW'(i + 1)) begin
        errors++;
        $display("FAIL drop rx[%0d]: got %h, expected %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, DW'(i + 1));
      end
    end
    checks++; if (status_overflow !== EXP_OVF) begin errors++; $display("FAIL drop ovf sticky: got %b, expected %b", status_overflow, EXP_OVF); end
  endtask

  task automatic test_ovf_clear();
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    checks++; if (status_overflow !== 1'b0) begin errors++; $display("FAIL ovf cleared: got %b, expected 0", status_overflow); end
    clear_log();
    tx_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'hB0 + DW'(i));
    ovf_clear = 1'b1;             // clear and dropped push on the same edge
    push_byte(8'hBF);
    ovf_clear = 1'b0;
    checks++; if (status_overflow !== EXP_OVF) begin errors++; $display("FAIL ovf set_wins: got %b, expected %b", status_overflow, EXP_OVF); end
    tx_hold = 1'b0;
    wait_pulses(4, "ovf_drain");
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
  endtask

  task automatic test_push_pop_full();
    logic [DW-1:0] exp_b [5];
    exp_b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h99};
    clear_log();
    tx_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(exp_b[i]);
    checks++; if (status_full !== 1'b1) begin errors++; $display("FAIL pp full before: got %b, expected 1", status_full); end
    tx_hold = 1'b0;               // pop happens on the next edge
    push_byte(8'h99);
    checks++; if (status_count !== 3'd4) begin errors++; $display("FAIL pp count: got %0d, expected 4", status_count); end
    checks++; if (tx_strobe_start !== 1'b1) begin errors++; $display("FAIL pp strobe: got %b, expected 1", tx_strobe_start); end
    checks++; if (status_overflow !== 1'b0) begin errors++; $display("FAIL pp no_ovf: got %b, expected 0", status_overflow); end
    wait_pulses(5, "push_pop_full");
    foreach (exp_b[i]) begin
      checks++;
      if (rx_q.size() <= i || rx_q[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL pp rx[%0d]: got %h, expected %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    clear_log();
    wr_en = 1'b1;
    wr_data = 8'hC1; tick();
    wr_data = 8'hC2; tick();
    wr_data = 8'hC3; tick();
    wr_en = 1'b0;
    cyc = 0;
    while (tx_strobe_start !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    checks++; if (tx_strobe_start !== 1'b1) begin errors++; $display("FAIL rmid strobe seen: got %b, expected 1", tx_strobe_start); end
    #2 reset = 1'b1;              // mid-cycle: reset must act without a clock edge
    #1;
    checks++; if (tx_strobe_start !== 1'b0) begin errors++; $display("FAIL rmid strobe: got %b, expected 0", tx_strobe_start); end
    checks++; if (tx_parallel_data_out !== 8'h00) begin errors++; $display("FAIL rmid data: got %h, expected 00", tx_parallel_data_out); end
    checks++; if (status_empty !== 1'b1) begin errors++; $display("FAIL rmid empty: got %b, expected 1", status_empty); end
    checks++; if (status_count !== 3'd0) begin errors++; $display("FAIL rmid count: got %0d, expected 0", status_count); end
    repeat (2) tick();
    reset = 1'b0;
    clear_log();
    repeat (60) tick();
    checks++; if (pulse_cnt !== 0) begin errors++; $display("FAIL rmid relaunch: got %0d, expected 0", pulse_cnt); end
    push_byte(8'h5A);
    wait_pulses(1, "rmid_after");
    checks++; if (rx_q.size() < 1 || rx_q[0] !== 8'h5A) begin errors++; $display("FAIL rmid new byte: got %h, expected 5a", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    wr_en     = 1'b0;
    wr_data   = '0;
    ovf_clear = 1'b0;
    tx_hold   = 1'b0;
    pulse_cnt = 0;
    launch_viol = 0;
    reset     = 1'b1;

    test_reset();
    test_single();
    test_burst_order();
    test_full_drop();
    test_ovf_clear();
    test_push_pop_full();
    test_reset_mid_burst();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
